sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_WIDTH, 16, address bits
  DATA_WIDTH, 16, data bits
  READ_CYCLES, 3, clocks notOE held low before read data capture (>=1)
  WRITE_CYCLES, 2, clocks notWE held low (>=1)
REQ-002 Ports SHALL be, one per line:
  clock  in  1  single system clock, rising edge
  reset  in  1  asynchronous, active-high
  req  in  1  access request, level, sampled only in IDLE
  we  in  1  1=write, 0=read, sampled with req
  addr  in  ADDR_WIDTH  access address, sampled with req
  wdata  in  DATA_WIDTH  write data, sampled with req
  busy  out  1  high in every state except IDLE
  ack  out  1  one-clock completion pulse
  rdata  out  DATA_WIDTH  read result, valid from ack until next read ack
  sram_addr  out  ADDR_WIDTH  external SRAM address
  sram_data  inout  DATA_WIDTH  external SRAM data bus
  sram_notCS  out  1  chip select, active-low
  sram_notOE  out  1  output enable, active-low
  sram_notWE  out  1  write enable, active-low

Function
REQ-003 FSM states SHALL be IDLE, RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-004 IDLE: req=1 at a rising edge SHALL latch addr/we/wdata; next state RD_ACCESS if we=0, else WR_SETUP.
REQ-005 RD_ACCESS SHALL last exactly READ_CYCLES clocks with notCS=0, notOE=0, notWE=1, sram_data tristated.
REQ-006 On the rising edge ending RD_ACCESS, sram_data SHALL be captured into rdata; next state DONE.
REQ-007 WR_SETUP SHALL last 1 clock: notCS=0, notWE=1, notOE=1, sram_data driven with latched wdata.
REQ-008 WR_PULSE SHALL last exactly WRITE_CYCLES clocks: notCS=0, notWE=0, notOE=1, data driven.
REQ-009 WR_HOLD SHALL last 1 clock: notCS=0, notWE=1, notOE=1, data still driven; next state DONE.
REQ-010 DONE SHALL last 1 clock: ack=1, all strobes high, bus tristated; next state IDLE unconditionally.
REQ-011 Latency: accept-edge to ack-high SHALL be READ_CYCLES+1 clocks for reads, WRITE_CYCLES+3 for writes.
REQ-012 Back-to-back: req held high SHALL give exactly one IDLE clock (notCS=1) between accesses.
REQ-013 sram_addr SHALL equal the latched address and stay stable from WR_SETUP/RD_ACCESS entry through DONE.
REQ-014 sram_data SHALL be driven only in WR_SETUP, WR_PULSE and WR_HOLD; notOE=0 and driven bus SHALL never coincide.
REQ-015 All strobes, ack and busy SHALL be registered outputs, glitch-free.
REQ-016 Inputs changing while busy=1 SHALL have no effect on the access in progress.
REQ-017 The wait counter SHALL be $clog2(max(READ_CYCLES,WRITE_CYCLES)+1) bits, load on state entry, and never wrap.

Reset
REQ-018 reset=1 SHALL immediately, asynchronously set state IDLE, notCS=notOE=notWE=1, sram_data tristated, ack=0, busy=0, rdata=0, sram_addr=0, counter=0.
REQ-019 Reset mid-write SHALL terminate the notWE pulse at once; no ack SHALL follow for the aborted access.
REQ-020 The first req SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-021 The state encodings and default timing constants SHALL live in shared package sram_pkg.
REQ-022 One sub-module, sram_wait_counter (load value, decrement, zero flag), SHALL implement the wait states.

Verification
REQ-023 Bench SHALL connect a behavioural async SRAM (55 ns read access) with a 20 ns clock and cover:
  - Write 0xBEEF to 0x0010, then read 0x0010 -> read ack 4 clocks after accept, rdata=0xBEEF.
  - req held high for 4 alternating write/read accesses -> exactly one notCS=1 clock between each, all acks single-clock.
  - Reset asserted in the 2nd WR_PULSE clock -> strobes high within the same clock, no ack; location keeps old value or aborted data, next read completes normally.
  - addr/wdata toggled every clock while busy -> written location and data match values sampled at accept.
  - READ_CYCLES=1, WRITE_CYCLES=1 build -> read ack 2 clocks, write ack 4 clocks after accept, data correct.
  - Assertion throughout: never (notOE=0 and sram_data driven by controller); notWE=0 only while notCS=0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared state encoding and default timing for the asynchronous SRAM controller.
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACCESS,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_READ_CYCLES  = 3;
  localparam int DEF_WRITE_CYCLES = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Saturating down-counter for SRAM wait states; load wins over decrement.
module sram_wait_counter
  import sram_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one read or write per request,
// with all strobes, ack and busy registered from the next state.
//   state     | meaning
//   IDLE      | waiting for req, bus released
//   RD_ACCESS | CS/OE low for READ_CYCLES, capture on last edge
//   WR_SETUP  | CS low, data driven, WE still high
//   WR_PULSE  | CS/WE low for WRITE_CYCLES, data driven
//   WR_HOLD   | WE released, data held one more clock
//   DONE      | ack pulse, strobes high, bus released
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_CYCLES  = DEF_READ_CYCLES,
  parameter int WRITE_CYCLES = DEF_WRITE_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_notCS,
  output logic                  sram_notOE,
  output logic                  sram_notWE
);

  localparam int CNT_W = $clog2(max_int(READ_CYCLES, WRITE_CYCLES) + 1);

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  bus_drive;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]      cnt_val;
  logic                  cs_nx, oe_nx, we_nx, drive_nx, ack_nx, busy_nx;

  sram_wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = (state == RD_ACCESS) || (state == WR_PULSE);
    case (state)
      IDLE: begin
        if (req) begin
          if (we) begin
            state_nx = WR_SETUP;
          end else begin
            state_nx = RD_ACCESS;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(READ_CYCLES - 1);
          end
        end
      end
      RD_ACCESS: if (cnt_zero) state_nx = DONE;
      WR_SETUP: begin
        state_nx = WR_PULSE;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(WRITE_CYCLES - 1);
      end
      WR_PULSE:  if (cnt_zero) state_nx = WR_HOLD;
      WR_HOLD:   state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase

    // Outputs follow the state being entered so the registered copies line up with it.
    cs_nx    = !(state_nx inside {RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD});
    oe_nx    = (state_nx != RD_ACCESS);
    we_nx    = (state_nx != WR_PULSE);
    drive_nx = (state_nx inside {WR_SETUP, WR_PULSE, WR_HOLD});
    ack_nx   = (state_nx == DONE);
    busy_nx  = (state_nx != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sram_notCS <= 1'b1;
      sram_notOE <= 1'b1;
      sram_notWE <= 1'b1;
      bus_drive  <= 1'b0;
      ack        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      sram_notCS <= cs_nx;
      sram_notOE <= oe_nx;
      sram_notWE <= we_nx;
      bus_drive  <= drive_nx;
      ack        <= ack_nx;
      busy       <= busy_nx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sram_addr <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
    end else begin
      if ((state == IDLE) && req) begin
        sram_addr <= addr;
        wdata_q   <= wdata;
      end
      if ((state == RD_ACCESS) && cnt_zero) begin
        rdata <= sram_data;
      end
    end
  end

  assign sram_data = bus_drive ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural async SRAMs, scoreboard of expected acks,
// and a second fast-timing instance.
module tb_sram_ctrl;

  localparam int RC = 3;
  localparam int WC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic        busy, ack;
  logic [15:0] rdata, sram_addr;
  wire  [15:0] sram_data;
  logic        sram_notCS, sram_notOE, sram_notWE;

  logic        f_req = 1'b0, f_we = 1'b0;
  logic [15:0] f_addr = '0, f_wdata = '0;
  logic        f_busy, f_ack;
  logic [15:0] f_rdata, f_sram_addr;
  wire  [15:0] f_sram_data;
  logic        f_notCS, f_notOE, f_notWE;

  always #10 clock = ~clock;

  sram_ctrl dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .ack(ack), .rdata(rdata), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_notCS(sram_notCS), .sram_notOE(sram_notOE), .sram_notWE(sram_notWE)
  );

  sram_ctrl #(.READ_CYCLES(1), .WRITE_CYCLES(1)) dut_f (
    .clock(clock), .reset(reset), .req(f_req), .we(f_we), .addr(f_addr), .wdata(f_wdata),
    .busy(f_busy), .ack(f_ack), .rdata(f_rdata), .sram_addr(f_sram_addr), .sram_data(f_sram_data),
    .sram_notCS(f_notCS), .sram_notOE(f_notOE), .sram_notWE(f_notWE)
  );

  // Main SRAM: 55 ns read access, write latched on the rising edge of notWE.
  logic [15:0] mem [0:65535];
  logic        m_oe, m_valid = 1'b0;
  assign m_oe = !sram_notCS && !sram_notOE;
  assign sram_data = (m_oe && m_valid) ? mem[sram_addr] : 16'hzzzz;
  initial forever begin
    @(posedge m_oe);
    #55;
    if (m_oe) begin
      m_valid = 1'b1;
      @(negedge m_oe);
      m_valid = 1'b0;
    end
  end
  always @(posedge sram_notWE) if (!sram_notCS) mem[sram_addr] = sram_data;

  // Fast part for the single-cycle build: one 20 ns clock of OE must suffice.
  logic [15:0] f_mem [0:65535];
  logic        f_oe, f_valid = 1'b0;
  assign f_oe = !f_notCS && !f_notOE;
  assign f_sram_data = (f_oe && f_valid) ? f_mem[f_sram_addr] : 16'hzzzz;
  initial forever begin
    @(posedge f_oe);
    #15;
    if (f_oe) begin
      f_valid = 1'b1;
      @(negedge f_oe);
      f_valid = 1'b0;
    end
  end
  always @(posedge f_notWE) if (!f_notCS) f_mem[f_sram_addr] = f_sram_data;

  typedef struct {
    bit          is_read;
    logic [15:0] data;
    logic [15:0] alt;
    int          lat;
    time         t_acc;
  } item_t;

  item_t       sb_q[$];
  logic [15:0] ref_mem [int];
  int          tests = 0, fails = 0;
  bit          alt_valid = 1'b0;
  logic [15:0] alt_addr = '0, alt_val = '0;
  item_t       mon_it;
  logic        ack_d = 1'b0;
  int          mon_lat;

  task automatic issue(input bit w, input logic [15:0] a, input logic [15:0] d, input bit toggle);
    int    n;
    item_t it;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    req = 1'b1; we = w; addr = a; wdata = d;
    if (w) ref_mem[a] = d;
    @(posedge clock);
    #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL accept: addr=%h busy=%b, want 1", a, busy);
    end
    it.is_read = !w;
    it.data    = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    it.alt     = (alt_valid && a == alt_addr) ? alt_val : it.data;
    it.lat     = w ? WC + 3 : RC + 1;
    it.t_acc   = $time - 1;
    sb_q.push_back(it);
    req = 1'b0;
    if (toggle) begin
      n = 0;
      while (busy && n < 20) begin
        @(negedge clock);
        n++;
        if (!sram_notCS) begin
          tests++;
          if (sram_addr !== a) begin
            fails++;
            $display("FAIL addr_stable: sram_addr=%h, want %h", sram_addr, a);
          end
        end
        addr = 16'($urandom); wdata = 16'($urandom); we = 1'($urandom);
      end
    end else begin
      @(negedge clock);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 40) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (n >= 40) begin
      fails++;
      $display("FAIL timeout: busy=%b pending=%0d, want idle and empty", busy, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    #5 reset = 1'b1;
    #10;
    tests += 8;
    if (busy !== 1'b0)       begin fails++; $display("FAIL rst_busy: %b, want 0", busy); end
    if (ack !== 1'b0)        begin fails++; $display("FAIL rst_ack: %b, want 0", ack); end
    if (rdata !== 16'h0)     begin fails++; $display("FAIL rst_rdata: %h, want 0", rdata); end
    if (sram_addr !== 16'h0) begin fails++; $display("FAIL rst_addr: %h, want 0", sram_addr); end
    if (sram_notCS !== 1'b1) begin fails++; $display("FAIL rst_cs: %b, want 1", sram_notCS); end
    if (sram_notOE !== 1'b1) begin fails++; $display("FAIL rst_oe: %b, want 1", sram_notOE); end
    if (sram_notWE !== 1'b1) begin fails++; $display("FAIL rst_we: %b, want 1", sram_notWE); end
    if (dut.bus_drive !== 1'b0) begin fails++; $display("FAIL rst_bus: drive=%b, want 0", dut.bus_drive); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    issue(1'b1, 16'h0010, 16'hBEEF, 1'b0);
    issue(1'b0, 16'h0010, 16'h0000, 1'b0);
    issue(1'b1, 16'h0011, 16'h0001, 1'b0);
    issue(1'b0, 16'h0011, 16'h0000, 1'b0);
    issue(1'b0, 16'h0010, 16'h0000, 1'b0);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    item_t it;
    int    n;
    req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      we = (k % 2 == 0); addr = 16'h0050 + 16'(k / 2); wdata = 16'hC000 + 16'(k);
      if (we) ref_mem[addr] = wdata;
      @(posedge clock);
      #1;
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL b2b_accept: k=%0d busy=%b, want 1", k, busy);
      end
      it.is_read = !we;
      it.data    = ref_mem[addr];
      it.alt     = it.data;
      it.lat     = we ? WC + 3 : RC + 1;
      it.t_acc   = $time - 1;
      sb_q.push_back(it);
      n = 0;
      @(negedge clock);
      while (busy && n < 20) begin
        @(negedge clock);
        n++;
      end
      tests++;
      if (busy !== 1'b0 || sram_notCS !== 1'b1) begin
        fails++;
        $display("FAIL b2b_idle: k=%0d busy=%b notCS=%b, want 0/1", k, busy, sram_notCS);
      end
    end
    req = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid_write();
    issue(1'b1, 16'h0030, 16'h1111, 1'b0);
    wait_idle();
    req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'h2222;
    @(posedge clock);
    req = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #5 reset = 1'b1;
    #1;
    tests += 5;
    if (sram_notWE !== 1'b1) begin fails++; $display("FAIL abort_we: %b, want 1", sram_notWE); end
    if (sram_notCS !== 1'b1) begin fails++; $display("FAIL abort_cs: %b, want 1", sram_notCS); end
    if (sram_notOE !== 1'b1) begin fails++; $display("FAIL abort_oe: %b, want 1", sram_notOE); end
    if (busy !== 1'b0)       begin fails++; $display("FAIL abort_busy: %b, want 0", busy); end
    if (dut.bus_drive !== 1'b0) begin fails++; $display("FAIL abort_bus: drive=%b, want 0", dut.bus_drive); end
    @(negedge clock);
    reset = 1'b0;
    alt_valid = 1'b1; alt_addr = 16'h0030; alt_val = 16'h2222;
    issue(1'b0, 16'h0030, 16'h0000, 1'b0);
    wait_idle();
    alt_valid = 1'b0;
  endtask

  task automatic test_input_toggle();
    issue(1'b1, 16'h0020, 16'h1234, 1'b1);
    issue(1'b0, 16'h0020, 16'h0000, 1'b1);
    issue(1'b0, 16'h0010, 16'h0000, 1'b0);
    wait_idle();
  endtask

  task automatic test_fast_build();
    bit          fw  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] fa  [4] = '{16'h0040, 16'h0040, 16'h0041, 16'h0041};
    logic [15:0] fd  [4] = '{16'hA5A5, 16'h0000, 16'h5A5A, 16'h0000};
    logic [15:0] fex [4] = '{16'h0000, 16'hA5A5, 16'h0000, 16'h5A5A};
    int          n;
    bit          seen;
    for (int k = 0; k < 4; k++) begin
      f_req = 1'b1; f_we = fw[k]; f_addr = fa[k]; f_wdata = fd[k];
      @(posedge clock);
      #1 f_req = 1'b0;
      n = 0; seen = 1'b0;
      while (!seen && n < 10) begin
        @(negedge clock);
        n++;
        if (f_ack) seen = 1'b1;
      end
      tests++;
      if (n != (fw[k] ? 4 : 2) || !seen) begin
        fails++;
        $display("FAIL fast_latency: k=%0d got %0d clocks, want %0d", k, n, fw[k] ? 4 : 2);
      end
      if (!fw[k]) begin
        tests++;
        if (f_rdata !== fex[k]) begin
          fails++;
          $display("FAIL fast_rdata: got %h, want %h", f_rdata, fex[k]);
        end
      end
      @(negedge clock);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clock);
        if (!sram_notOE && dut.bus_drive) begin
          fails++; $display("FAIL bus_conflict: notOE=0 with controller driving");
        end
        if (!f_notOE && dut_f.bus_drive) begin
          fails++; $display("FAIL fast_bus_conflict: notOE=0 with controller driving");
        end
        if (!sram_notWE && sram_notCS) begin
          fails++; $display("FAIL we_without_cs: notWE=0 notCS=1");
        end
        if (!f_notWE && f_notCS) begin
          fails++; $display("FAIL fast_we_without_cs: notWE=0 notCS=1");
        end
        if (ack) begin
          tests++;
          if (ack_d) begin
            fails++; $display("FAIL ack_width: ack high two clocks, want one");
          end else if (sb_q.size() == 0) begin
            fails++; $display("FAIL unexpected_ack: ack=1 with nothing outstanding");
          end else begin
            mon_it  = sb_q.pop_front();
            mon_lat = int'(($time - mon_it.t_acc + 10) / 20);
            if (mon_lat != mon_it.lat) begin
              fails++; $display("FAIL latency: got %0d clocks, want %0d", mon_lat, mon_it.lat);
            end
            if (mon_it.is_read && rdata !== mon_it.data && rdata !== mon_it.alt) begin
              fails++; $display("FAIL rdata: got %h, want %h (or %h)", rdata, mon_it.data, mon_it.alt);
            end
          end
        end
        ack_d = ack;
      end
    join_none
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid_write();
    test_input_toggle();
    test_fast_build();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
